lfsr_period_monitor: RTL and testbench
======================================

Name: lfsr_period_monitor

Overview:
- Downstream consumer of the 7-bit Fibonacci LFSR register.
- Samples the register's parallel output stream and measures the sequence period and the LSB balance (number of 1s).
- Flags lock-up (all-zero state) and non-returning streams.
- Replaces file-dump inspection of the LFSR with an in-circuit pass/fail verdict (maximal-length check).

Parameters:
- WIDTH, 7, width of monitored LFSR state.
- CNT_W, WIDTH+1, width of period/ones counters; must hold 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock, shared with LFSR.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; arms a measurement.
- in_valid  input  1  in_data carries a new LFSR state this cycle.
- in_data  input  WIDTH  LFSR state (bits [WIDTH:1] of upstream map to [WIDTH-1:0] here).
- busy  output  1  high in CAPTURE or MEASURE.
- done  output  1  level; high in DONE until next start.
- period  output  CNT_W  measured period; 0 on lockup or timeout.
- ones  output  CNT_W  count of counted samples with in_data[0]=1.
- maximal  output  1  period==2^WIDTH-1 and ones==2^(WIDTH-1).
- lockup  output  1  all-zero sample seen.
- timeout  output  1  2^WIDTH samples counted with no return to reference.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. ref, cnt, and ones cleared. All outputs 0. Takes effect immediately, including mid-measurement.
- All outputs are registered. Samples are accepted only when in_valid=1 on a rising clk edge.
- FSM states: IDLE, CAPTURE, MEASURE, DONE.
- IDLE: start=1 -> CAPTURE. Clear period, ones, maximal, lockup, timeout, and cnt.
- CAPTURE, on valid sample:
  - in_data==0 -> DONE with lockup=1.
  - Otherwise ref<=in_data -> MEASURE. The reference sample is not counted.
- MEASURE, on valid sample d (checked in priority order):
  - d==0 -> DONE; lockup=1, period=0.
  - d==ref -> DONE; period<=cnt+1, ones<=ones+d[0].
  - cnt+1==2^WIDTH -> DONE; timeout=1, period=0.
  - Otherwise cnt<=cnt+1, ones<=ones+d[0], stay in MEASURE.
- No valid sample: state and counters hold. Gaps in in_valid are allowed anywhere.
- DONE:
  - done=1. period, ones, lockup, and timeout hold.
  - maximal is computed on the DONE entry edge (registered). Forced 0 if lockup or timeout.
  - start=1 -> CAPTURE with all results cleared the same edge. done drops the next cycle.
- start is ignored in CAPTURE and MEASURE; there is no restart mid-measurement.
- start coinciding with in_valid in IDLE/DONE: that sample is NOT captured. Capture uses the first valid sample after the start edge.
- Latency: done is visible the cycle after the edge accepting the terminating sample. busy falls on that same edge.
- Counter widths: cnt and ones never exceed 2^WIDTH (timeout bounds them). No wrap is possible at CNT_W=WIDTH+1.
- WIDTH-generic: no 7-specific constants in logic.

Test Plan:
1. Maximal LFSR x^7+x^6+1, seed 7'h01, in_valid=1 continuous, start pulse -> after 128 valid samples (1 ref + 127): done=1, period=127, ones=64, maximal=1, lockup=0, timeout=0.
2. Same stream with in_valid toggling 1/0 every cycle -> identical results; done rises exactly one cycle after the 128th accepted sample; busy=1 throughout.
3. Repeating stream 5,9,5,9,... -> ref=5, period=2, ones=2, maximal=0; then a start pulse in DONE with stream 3,3 -> period=1, ones=1.
4. Maximal stream with 7'h00 substituted as the 10th sample -> DONE with lockup=1, period=0, maximal=0; a zero as the very first sample after start also gives lockup=1.
5. Stream 3 then 1,2,1,2,... (never 3 again) -> after 128 counted samples: timeout=1, period=0, done=1, maximal=0.
6. rst_n pulsed low mid-MEASURE (asynchronously, between clock edges) -> busy/done/outputs 0 immediately; after release, start plus maximal stream reproduces scenario 1 results.

Source files
------------

// File: rtl/lfsr_period_monitor.sv
// rtl/lfsr_period_monitor.sv - LFSR stream period/balance monitor with maximal-length verdict
module lfsr_period_monitor #(
  parameter int WIDTH = 7,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] ones,
  output logic             maximal,
  output logic             lockup,
  output logic             timeout
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_MEASURE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(1) << WIDTH;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ones_q, ones_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               maximal_q, maximal_d;
  logic               lockup_q, lockup_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   ones_inc;
  logic               is_zero;
  logic               is_ref;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign ones_inc = ones_q + CNT_W'(in_data[0]);
  assign is_zero  = (in_data == '0);
  assign is_ref   = (in_data == ref_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ref_q     <= '0;
      cnt_q     <= '0;
      ones_q    <= '0;
      period_q  <= '0;
      maximal_q <= 1'b0;
      lockup_q  <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      period_q  <= period_d;
      maximal_q <= maximal_d;
      lockup_q  <= lockup_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CAPTURE;
      S_CAPTURE: if (in_valid) state_d = is_zero ? S_DONE : S_MEASURE;
      S_MEASURE: if (in_valid && (is_zero || is_ref || cnt_inc == FULL)) state_d = S_DONE;
      S_DONE:    if (start) state_d = S_CAPTURE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ref_d     = ref_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    period_d  = period_q;
    maximal_d = maximal_q;
    lockup_d  = lockup_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d     = '0;
          ones_d    = '0;
          period_d  = '0;
          maximal_d = 1'b0;
          lockup_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (in_valid) begin
          if (is_zero) lockup_d = 1'b1;
          else         ref_d    = in_data;
        end
      end
      S_MEASURE: begin
        // Priority: lock-up, return to reference, then sample budget exhausted.
        if (in_valid) begin
          if (is_zero) begin
            lockup_d = 1'b1;
            period_d = '0;
          end else if (is_ref) begin
            period_d  = cnt_inc;
            ones_d    = ones_inc;
            maximal_d = (cnt_inc == FULL - CNT_W'(1)) && (ones_inc == (FULL >> 1));
          end else if (cnt_inc == FULL) begin
            timeout_d = 1'b1;
            period_d  = '0;
          end else begin
            cnt_d  = cnt_inc;
            ones_d = ones_inc;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d == S_CAPTURE) || (state_d == S_MEASURE);
    done_d = (state_d == S_DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign period  = period_q;
  assign ones    = ones_q;
  assign maximal = maximal_q;
  assign lockup  = lockup_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// tb/tb_lfsr_period_monitor.sv - bench for lfsr_period_monitor
module tb_lfsr_period_monitor;

  localparam int W    = 7;
  localparam int CW   = W + 1;
  localparam int FULL = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          busy, done, maximal, lockup, timeout;
  logic [CW-1:0] period, ones;

  lfsr_period_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .done(done), .period(period), .ones(ones),
    .maximal(maximal), .lockup(lockup), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int scen;
    int gap;
    int period;
    int ones;
    int maximal;
    int lockup;
    int timeout;
    int acc;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int stim_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    return {s[W-2:0], s[W-1] ^ s[W-2]};
  endfunction

  task automatic push_lfsr(input logic [W-1:0] seed, input int n);
    logic [W-1:0] s;
    s = seed;
    for (int i = 0; i < n; i++) begin
      stim_q.push_back(int'(s));
      s = lfsr_next(s);
    end
  endtask

  task automatic build(input int scen);
    stim_q.delete();
    case (scen)
      0, 1: push_lfsr(7'h01, 200);
      2: for (int i = 0; i < 20; i++) stim_q.push_back((i % 2 == 0) ? 5 : 9);
      3: for (int i = 0; i < 20; i++) stim_q.push_back(3);
      4: begin push_lfsr(7'h01, 200); stim_q[9] = 0; end
      5: begin stim_q.push_back(0); push_lfsr(7'h01, 20); end
      6: begin
        stim_q.push_back(3);
        for (int i = 0; i < 200; i++) stim_q.push_back((i % 2 == 0) ? 1 : 2);
      end
      default: ;
    endcase
  endtask

  // Walks the sample list directly from the measurement rules.
  function automatic vec_t model_of();
    vec_t r;
    int refv, acc1;
    r = '{scen: -1, gap: 0, period: 0, ones: 0, maximal: 0, lockup: 0, timeout: 0, acc: -1};
    if (stim_q[0] == 0) begin
      r.lockup = 1; r.acc = 1;
      return r;
    end
    refv = stim_q[0];
    acc1 = 0;
    for (int k = 1; k < stim_q.size(); k++) begin
      if (stim_q[k] == 0) begin
        r.lockup = 1; r.ones = acc1; r.acc = k + 1;
        return r;
      end
      if (stim_q[k] == refv) begin
        r.period = k; r.ones = acc1 + (stim_q[k] % 2); r.acc = k + 1;
        r.maximal = (r.period == FULL - 1 && r.ones == FULL / 2) ? 1 : 0;
        return r;
      end
      if (k == FULL) begin
        r.timeout = 1; r.ones = acc1; r.acc = k + 1;
        return r;
      end
      acc1 += stim_q[k] % 2;
    end
    return r;
  endfunction

  task automatic run_case(input string tag, input vec_t e);
    int acc, it, v;
    bit busy_ok, early, reached;
    acc = 0; it = 0; busy_ok = 1; early = 0; reached = 0;
    // A valid sample on the start edge must not become the reference.
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 7'h55;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk({tag, ".busy_after_start"}, int'(busy), 1);
    chk({tag, ".done_after_start"}, int'(done), 0);
    while (acc < stim_q.size() && it < 2000) begin
      v = (e.gap == 0) ? 1 : (e.gap == 1) ? ((it % 2 == 0) ? 1 : 0) : int'($urandom_range(0, 1));
      in_valid = v[0];
      in_data = v[0] ? W'(stim_q[acc]) : W'($urandom);
      @(negedge clk);
      it++;
      if (v == 1) acc++;
      if (v == 1 && acc == e.acc) begin reached = 1; break; end
      if (done) begin early = 1; break; end
      if (!busy) busy_ok = 0;
    end
    in_valid = 1'b0;
    chk({tag, ".reached_term"}, int'(reached), 1);
    chk({tag, ".early_done"}, int'(early), 0);
    chk({tag, ".busy_throughout"}, int'(busy_ok), 1);
    chk({tag, ".done_latency"}, int'(done), 1);
    chk({tag, ".busy_at_done"}, int'(busy), 0);
    chk({tag, ".period"}, int'(period), e.period);
    chk({tag, ".ones"}, int'(ones), e.ones);
    chk({tag, ".maximal"}, int'(maximal), e.maximal);
    chk({tag, ".lockup"}, int'(lockup), e.lockup);
    chk({tag, ".timeout"}, int'(timeout), e.timeout);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, ".done_hold"}, int'(done), 1);
    chk({tag, ".period_hold"}, int'(period), e.period);
    chk({tag, ".ones_hold"}, int'(ones), e.ones);
  endtask

  vec_t vecs[7];
  vec_t e;

  initial begin
    vecs[0] = '{scen: 0, gap: 0, period: 127, ones: 64, maximal: 1, lockup: 0, timeout: 0, acc: 128};
    vecs[1] = '{scen: 1, gap: 1, period: 127, ones: 64, maximal: 1, lockup: 0, timeout: 0, acc: 128};
    vecs[2] = '{scen: 2, gap: 0, period: 2,   ones: 2,  maximal: 0, lockup: 0, timeout: 0, acc: 3};
    vecs[3] = '{scen: 3, gap: 0, period: 1,   ones: 1,  maximal: 0, lockup: 0, timeout: 0, acc: 2};
    vecs[4] = '{scen: 4, gap: 0, period: 0,   ones: 2,  maximal: 0, lockup: 1, timeout: 0, acc: 10};
    vecs[5] = '{scen: 5, gap: 2, period: 0,   ones: 0,  maximal: 0, lockup: 1, timeout: 0, acc: 1};
    vecs[6] = '{scen: 6, gap: 2, period: 0,   ones: 64, maximal: 0, lockup: 0, timeout: 1, acc: 129};

    repeat (2) @(negedge clk);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.period", int'(period), 0);
    chk("reset.maximal", int'(maximal), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      build(vecs[i].scen);
      run_case($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of a measurement.
    build(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_data = W'(stim_q[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midrst.busy_before", int'(busy), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    chk("midrst.ones", int'(ones), 0);
    chk("midrst.period", int'(period), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_case("after_rst", vecs[0]);

    for (int r = 0; r < 16; r++) begin
      int mode;
      mode = r % 4;
      stim_q.delete();
      case (mode)
        0: begin
          push_lfsr(W'($urandom_range(1, FULL - 1)), 140);
          if ($urandom_range(0, 1) == 1) stim_q[$urandom_range(1, 139)] = 0;
        end
        1: for (int i = 0; i < 140; i++) stim_q.push_back(int'($urandom_range(1, 7)));
        2: for (int i = 0; i < 140; i++) stim_q.push_back(int'($urandom_range(1, FULL - 1)));
        default: for (int i = 0; i < 140; i++)
          stim_q.push_back(($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 3)));
      endcase
      e = model_of();
      e.gap = 2;
      run_case($sformatf("rnd%0d", r), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
